// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier sharing arbiter.
// Imported by the arbiter top and its multiplier slice.
package mult_arb_pkg;

  localparam int DEF_WIDTH_A = 4;
  localparam int DEF_WIDTH_B = 6;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// Combinational unsigned multiplier shared by all requesters.
// Full-width product, no truncation.
module Multiplier
  import mult_arb_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
) (
  input  logic [WIDTH_A-1:0]         in1,
  input  logic [WIDTH_B-1:0]         in2,
  output logic [WIDTH_A+WIDTH_B-1:0] out
);

  localparam int PW = WIDTH_A + WIDTH_B;

  logic [PW-1:0] ext1;
  logic [PW-1:0] ext2;

  assign ext1 = {{WIDTH_B{1'b0}}, in1};
  assign ext2 = {{WIDTH_A{1'b0}}, in2};
  assign out  = ext1 * ext2;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one Multiplier
// between NUM_REQ valid/ready requesters.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B,
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W   = $clog2(NUM_REQ),
  localparam int PW     = WIDTH_A + WIDTH_B
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH_A-1:0] req_a,
  input  logic [NUM_REQ*WIDTH_B-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [PW-1:0]              rsp_prod
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_nxt;
  logic [ID_W-1:0]    gnt_id;
  logic               any_req;
  logic               take;

  logic [WIDTH_A-1:0] op_a;
  logic [WIDTH_B-1:0] op_b;
  logic [ID_W-1:0]    op_id;
  logic [PW-1:0]      mul_out;

  // Scan starting at rr_ptr so the last winner ranks lowest next time.
  always_comb begin
    any_req = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req &&
          req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        gnt_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign rr_nxt = (int'(gnt_id) == NUM_REQ - 1)
                ? '0
                : gnt_id + ID_W'(1);

  assign take = (state == IDLE) && any_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_req) state_nxt = CALC;
      CALC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): if (any_req) req_ready[gnt_id] = 1'b1;
      (state == RESP): rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
    end else if (take) begin
      rr_ptr <= rr_nxt;
      op_a   <= req_a[int'(gnt_id)*WIDTH_A +: WIDTH_A];
      op_b   <= req_b[int'(gnt_id)*WIDTH_B +: WIDTH_B];
      op_id  <= gnt_id;
    end
  end

  Multiplier #(
    .WIDTH_A(WIDTH_A),
    .WIDTH_B(WIDTH_B)
  ) u_mult (
    .in1(op_a),
    .in2(op_b),
    .out(mul_out)
  );

  // Product only loads in CALC, so it stays put while RESP stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_prod <= '0;
      rsp_id   <= '0;
    end else if (state == CALC) begin
      rsp_prod <= mul_out;
      rsp_id   <= op_id;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: vector table, directed corner sequences
// and a randomized run against a transaction-level reference.
module tb_mult_share_arbiter;

  localparam int WA = 4;
  localparam int WB = 6;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int PW = WA + WB;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WA-1:0] req_a;
  logic [N*WB-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [PW-1:0]   rsp_prod;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .WIDTH_A(WA),
    .WIDTH_B(WB),
    .NUM_REQ(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_prod (rsp_prod)
  );

  typedef struct {
    int id;
    int a;
    int b;
    int prod;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i]        = 1'b1;
    req_a[i*WA +: WA]   = WA'(a);
    req_b[i*WB +: WB]   = WB'(b);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    clr();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Full transaction for one requester, rsp_ready held high.
  task automatic single(input string nm, input int id,
                        input int a, input int b, input int prod);
    clr();
    set_req(id, a, b);
    rsp_ready = 1'b1;
    settle();
    chk({nm, " ready"}, 32'(req_ready), 32'(1 << id));
    tick();
    clr();
    settle();
    chk({nm, " calc ready"}, 32'(req_ready), 0);
    chk({nm, " calc valid"}, 32'(rsp_valid), 0);
    tick();
    chk({nm, " valid"}, 32'(rsp_valid), 1);
    chk({nm, " id"}, 32'(rsp_id), 32'(id));
    chk({nm, " prod"}, 32'(rsp_prod), 32'(prod));
    tick();
    chk({nm, " drop"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    int exp_g[5];
    int m_rr;
    int m_busy;
    int m_id;
    int m_prod;
    int g;
    bit any;
    logic [N-1:0] er;

    vecs[0] = '{2, 3, 5, 15};
    vecs[1] = '{0, 15, 63, 945};
    vecs[2] = '{3, 15, 63, 945};
    vecs[3] = '{1, 0, 63, 0};
    vecs[4] = '{3, 1, 1, 1};
    vecs[5] = '{1, 12, 40, 480};

    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    clr();
    #2;
    chk("rst valid", 32'(rsp_valid), 0);
    chk("rst ready", 32'(req_ready), 0);
    chk("rst prod", 32'(rsp_prod), 0);
    chk("rst id", 32'(rsp_id), 0);
    chk("rst rr", 32'(dut.rr_ptr), 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      single($sformatf("vec%0d", v), vecs[v].id,
             vecs[v].a, vecs[v].b, vecs[v].prod);
    end

    // Round robin with every requester pending.
    do_reset();
    exp_g = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) set_req(i, i + 1, 9);
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      settle();
      chk($sformatf("rr%0d ready", n), 32'(req_ready),
          32'(1 << exp_g[n]));
      tick();
      chk($sformatf("rr%0d calc", n), 32'(req_ready), 0);
      tick();
      chk($sformatf("rr%0d valid", n), 32'(rsp_valid), 1);
      chk($sformatf("rr%0d id", n), 32'(rsp_id), 32'(exp_g[n]));
      chk($sformatf("rr%0d prod", n), 32'(rsp_prod),
          32'((exp_g[n] + 1) * 9));
      tick();
    end
    clr();

    // Backpressure with another requester waiting.
    set_req(0, 7, 9);
    rsp_ready = 1'b0;
    settle();
    chk("bp accept", 32'(req_ready), 1);
    tick();
    clr();
    set_req(1, 1, 1);
    settle();
    chk("bp calc ready", 32'(req_ready), 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d valid", c), 32'(rsp_valid), 1);
      chk($sformatf("bp%0d prod", c), 32'(rsp_prod), 63);
      chk($sformatf("bp%0d id", c), 32'(rsp_id), 0);
      chk($sformatf("bp%0d ready", c), 32'(req_ready), 0);
      tick();
    end
    clr();
    rsp_ready = 1'b1;
    settle();
    chk("bp last valid", 32'(rsp_valid), 1);
    chk("bp last prod", 32'(rsp_prod), 63);
    tick();
    chk("bp released", 32'(rsp_valid), 0);

    // Pointer skip and wrap.
    do_reset();
    single("skip pre", 2, 2, 3, 6);
    chk("skip rr3", 32'(dut.rr_ptr), 3);
    clr();
    set_req(1, 2, 2);
    settle();
    chk("skip grant", 32'(req_ready), 32'(4'b0010));
    tick();
    clr();
    chk("skip rr2", 32'(dut.rr_ptr), 2);
    tick();
    chk("skip prod", 32'(rsp_prod), 4);
    tick();
    single("wrap", 3, 5, 6, 30);
    chk("wrap rr0", 32'(dut.rr_ptr), 0);

    // Reset while a response is stalled.
    clr();
    set_req(1, 5, 5);
    rsp_ready = 1'b0;
    tick();
    clr();
    tick();
    chk("mid valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(rsp_valid), 0);
    chk("mid rst prod", 32'(rsp_prod), 0);
    chk("mid rst rr", 32'(dut.rr_ptr), 0);
    chk("mid rst ready", 32'(req_ready), 0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid quiet%0d", c), 32'(rsp_valid), 0);
    end

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_rr   = 0;
    m_busy = 0;
    m_id   = 0;
    m_prod = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_a     = (N*WA)'($urandom());
      req_b     = (N*WB)'({$urandom(), $urandom()});
      rsp_ready = ($urandom_range(0, 3) != 0);
      settle();
      any = 1'b0;
      g   = 0;
      for (int k = 0; k < N; k++) begin
        if (!any && req_valid[(m_rr + k) % N]) begin
          any = 1'b1;
          g   = (m_rr + k) % N;
        end
      end
      er = '0;
      if (m_busy == 0 && any) er[g] = 1'b1;
      chk("rnd ready", 32'(req_ready), 32'(er));
      chk("rnd valid", 32'(rsp_valid), 32'(m_busy == 2));
      if (m_busy == 2) begin
        chk("rnd id", 32'(rsp_id), 32'(m_id));
        chk("rnd prod", 32'(rsp_prod), 32'(m_prod));
      end
      if (m_busy == 0 && any) begin
        m_id   = g;
        m_prod = int'(req_a[g*WA +: WA]) * int'(req_b[g*WB +: WB]);
        m_rr   = (g + 1) % N;
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_busy = 2;
      end else if (m_busy == 2 && rsp_ready) begin
        m_busy = 0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
